// File: rtl/apb_regfile_slave.sv
// APB register-file slave: DEPTH x DATA_W storage with byte strobes, programmable
// wait states, a read-only ID word at index 0 and PSLVERR on illegal accesses.
module apb_regfile_slave #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DEPTH    = 16,
  parameter logic [63:0] ID_VALUE = 64'h0000_0000_A9B0_0001
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  input  logic [3:0]          wait_cfg,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state, state_d;
  logic [3:0]          cnt, cnt_d;
  logic                pready_d;
  logic                pslverr_d;
  logic [DATA_W-1:0]   prdata_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   word_idx;
  logic [IDX_W-1:0]    word_sel;
  logic                misaligned;
  logic                out_of_range;
  logic                illegal;
  logic [DATA_W-1:0]   rd_val;
  logic [DATA_W-1:0]   resp_data;
  logic [DATA_W-1:0]   byte_mask;
  logic                wr_en;

  // Address decode and legality, evaluated on the (stable) APB address phase
  always_comb begin
    word_idx     = ADDR_W'(paddr >> OFF_W);
    word_sel     = IDX_W'(word_idx);
    misaligned   = (paddr & ADDR_W'(BYTES - 1)) != '0;
    out_of_range = 32'(word_idx) >= DEPTH;
    illegal      = misaligned | out_of_range | (pwrite & (word_idx == '0));
  end

  // Read mux: word 0 is the constant ID, illegal reads and all writes return 0
  always_comb begin
    rd_val = '0;
    if (word_idx == '0) begin
      rd_val = DATA_W'(ID_VALUE);
    end else if (!out_of_range) begin
      rd_val = mem[word_sel];
    end
    resp_data = (pwrite || illegal) ? '0 : rd_val;
  end

  for (genvar b = 0; b < BYTES; b++) begin : g_mask
    assign byte_mask[b*8 +: 8] = {8{pstrb[b]}};
  end

  // State and response registers
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state   <= IDLE;
      cnt     <= '0;
      pready  <= 1'b0;
      pslverr <= 1'b0;
      prdata  <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      pready  <= pready_d;
      pslverr <= pslverr_d;
      prdata  <= prdata_d;
    end
  end

  // Next-state and next-response logic
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    pready_d  = pready;
    pslverr_d = pslverr;
    prdata_d  = prdata;
    wr_en     = 1'b0;

    case (state)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (psel && !penable) begin
          cnt_d = wait_cfg;
          if (wait_cfg == 4'd0) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = illegal;
            prdata_d  = resp_data;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        if (!psel) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 4'd1;
          if (cnt == 4'd1) begin
            state_d   = RESP;
            pready_d  = 1'b1;
            pslverr_d = illegal;
            prdata_d  = resp_data;
          end
        end
      end

      RESP: begin
        if (!psel || penable) begin
          wr_en     = psel && penable && pwrite && !illegal;
          state_d   = IDLE;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end
      end

      default: begin
        state_d   = IDLE;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
      end
    endcase
  end

  // Storage words; word 0 is never write-enabled because writes to it are illegal
  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
        mem[w] <= '0;
      end else if (wr_en && (word_sel == IDX_W'(w))) begin
        mem[w] <= (mem[w] & ~byte_mask) | (pwdata & byte_mask);
      end
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: vector table plus hand-written abort/reset/wait sequences,
// with expected responses queued at setup and checked when pready rises.
module tb_apb_regfile_slave;

  localparam logic [31:0] ID = 32'hA9B0_0001;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [3:0]  wait_cfg;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  apb_regfile_slave dut (
    .pclk     (pclk),
    .preset   (preset),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .wait_cfg (wait_cfg),
    .pready   (pready),
    .prdata   (prdata),
    .pslverr  (pslverr)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [3:0]  wcfg;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[17];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One APB transfer; wcfg_mid replaces wait_cfg once the access phase has started
  task automatic apb_xfer(input string tag, input logic wr, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [3:0] wcfg, input logic [3:0] wcfg_mid,
                          input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    int   cyc;
    @(posedge pclk); #1;
    check({tag, "_idle_pready"}, 64'(pready), 64'(1'b0));
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wdata; pstrb = strb; wait_cfg = wcfg;
    sb.push_back('{exp_rdata, exp_err, int'(wcfg) + 1});
    @(posedge pclk); #1;
    penable  = 1'b1;
    wait_cfg = wcfg_mid;
    cyc      = 1;
    while (!pready && cyc < 40) begin
      @(posedge pclk); #1;
      cyc++;
    end
    e = sb.pop_front();
    check({tag, "_pready"}, 64'(pready), 64'(1'b1));
    check({tag, "_latency"}, 64'(cyc), 64'(e.lat));
    check({tag, "_prdata"}, 64'(prdata), 64'(e.rdata));
    check({tag, "_pslverr"}, 64'(pslverr), 64'(e.err));
  endtask

  task automatic bus_idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  initial begin
    logic ok;
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{1'b0, 8'h00, 32'h0,         4'h0, 4'd0,  ID,            1'b0};
    vecs[1]  = '{1'b0, 8'h14, 32'h0,         4'h0, 4'd0,  32'h0,         1'b0};
    vecs[2]  = '{1'b1, 8'h08, 32'hDEADBEEF,  4'h5, 4'd3,  32'h0,         1'b0};
    vecs[3]  = '{1'b0, 8'h08, 32'h0,         4'h0, 4'd3,  32'h00AD00EF,  1'b0};
    vecs[4]  = '{1'b1, 8'h00, 32'h11111111,  4'hF, 4'd1,  32'h0,         1'b1};
    vecs[5]  = '{1'b0, 8'h06, 32'h0,         4'h0, 4'd0,  32'h0,         1'b1};
    vecs[6]  = '{1'b0, 8'h40, 32'h0,         4'h0, 4'd2,  32'h0,         1'b1};
    vecs[7]  = '{1'b0, 8'h00, 32'h0,         4'h0, 4'd0,  ID,            1'b0};
    vecs[8]  = '{1'b1, 8'h04, 32'h11111111,  4'hF, 4'd0,  32'h0,         1'b0};
    vecs[9]  = '{1'b0, 8'h04, 32'h0,         4'h0, 4'd0,  32'h11111111,  1'b0};
    vecs[10] = '{1'b1, 8'h08, 32'hFFFFFFFF,  4'h0, 4'd1,  32'h0,         1'b0};
    vecs[11] = '{1'b0, 8'h08, 32'h0,         4'h0, 4'd1,  32'h00AD00EF,  1'b0};
    vecs[12] = '{1'b1, 8'h3C, 32'hCAFEF00D,  4'hA, 4'd15, 32'h0,         1'b0};
    vecs[13] = '{1'b0, 8'h3C, 32'h0,         4'h0, 4'd4,  32'hCA00F000,  1'b0};
    vecs[14] = '{1'b0, 8'h3D, 32'h0,         4'h0, 4'd0,  32'h0,         1'b1};
    vecs[15] = '{1'b1, 8'h08, 32'h12345678,  4'hA, 4'd0,  32'h0,         1'b0};
    vecs[16] = '{1'b0, 8'h08, 32'h0,         4'h0, 4'd0,  32'h12AD56EF,  1'b0};

    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; wait_cfg = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    check("reset_pready", 64'(pready), 64'(1'b0));
    check("reset_pslverr", 64'(pslverr), 64'(1'b0));
    check("reset_prdata", 64'(prdata), 64'(32'h0));

    // Table vectors, issued back-to-back
    for (int i = 0; i < 17; i++) begin
      apb_xfer($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
               vecs[i].strb, vecs[i].wcfg, vecs[i].wcfg, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    bus_idle();

    // wait_cfg raised mid-transfer must not stretch it
    apb_xfer("cfgchg", 1'b0, 8'h04, 32'h0, 4'h0, 4'd2, 4'd7, 32'h11111111, 1'b0);
    bus_idle();

    // psel dropped during WAIT: no response, no commit
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h08;
    pwdata = 32'h0; pstrb = 4'hF; wait_cfg = 4'd5;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
    ok = 1'b1;
    repeat (8) begin
      @(posedge pclk); #1;
      if (pready) ok = 1'b0;
    end
    check("abort_no_pready", 64'(ok), 64'(1'b1));
    apb_xfer("abort_rd", 1'b0, 8'h08, 32'h0, 4'h0, 4'd1, 4'd1, 32'h12AD56EF, 1'b0);
    bus_idle();

    // Reset mid-WAIT after a committed write
    apb_xfer("pre_wr", 1'b1, 8'h0C, 32'h12345678, 4'hF, 4'd0, 4'd0, 32'h0, 1'b0);
    apb_xfer("pre_rd", 1'b0, 8'h0C, 32'h0, 4'h0, 4'd0, 4'd0, 32'h12345678, 1'b0);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h0C;
    pwdata = 32'hFFFFFFFF; pstrb = 4'hF; wait_cfg = 4'd6;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1 preset = 1'b1;
    #1;
    check("rst_mid_pready", 64'(pready), 64'(1'b0));
    check("rst_mid_prdata", 64'(prdata), 64'(32'h0));
    ok = 1'b1;
    repeat (6) begin
      @(posedge pclk); #1;
      if (pready) ok = 1'b0;
    end
    check("rst_hold_no_pready", 64'(ok), 64'(1'b1));
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1 preset = 1'b0;
    apb_xfer("post_rst_w3", 1'b0, 8'h0C, 32'h0, 4'h0, 4'd0, 4'd0, 32'h0, 1'b0);
    apb_xfer("post_rst_w2", 1'b0, 8'h08, 32'h0, 4'h0, 4'd2, 4'd2, 32'h0, 1'b0);
    apb_xfer("post_rst_id", 1'b0, 8'h00, 32'h0, 4'h0, 4'd1, 4'd1, ID, 1'b0);
    bus_idle();

    repeat (2) @(posedge pclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
